// File: rtl/i2c_tcs_target_if.sv
// I2C pad bundle between a bus master (or bench) and the TCS3472 target model.
// The target never drives SDA high: sda_oe=1 pulls the open-drain line low.
interface i2c_tcs_target_if;
    logic scl_i;
    logic sda_i;
    logic sda_oe;

    modport master (
        output scl_i,
        output sda_i,
        input  sda_oe
    );

    modport slave (
        input  scl_i,
        input  sda_i,
        output sda_oe
    );
endinterface

// File: rtl/i2c_tcs_target.sv
// I2C target emulating the TCS3472 colour sensor register interface.
// Optional TCS_SHADOW_LATCH_EN: a CDATAL read snapshots all channel inputs.
module i2c_tcs_target #(
    parameter logic [6:0] DEVICE_ADDRESS = 7'h29,
    parameter logic [7:0] ID_VALUE       = 8'h44,
    parameter int         FILTER_LEN     = 3
) (
    input  logic              clk,
    input  logic              rst,
    i2c_tcs_target_if.slave   bus,
    input  logic [15:0]       clear_in,
    input  logic [15:0]       red_in,
    input  logic [15:0]       green_in,
    input  logic [15:0]       blue_in,
    input  logic              data_valid_in,
    output logic              pon,
    output logic              aen,
    output logic [7:0]        atime,
    output logic [1:0]        again,
    output logic              reg_wr,
    output logic [4:0]        reg_wr_addr,
    output logic              busy
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        CMD,
        CMD_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        IGNORE
    } state_t;

    // index 1 = SCL, index 0 = SDA
    logic [1:0]    pad;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    filt;
    logic [1:0]    filt_q;
    logic [CW-1:0] flt_cnt [2];

    logic scl;
    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start_c;
    logic stop_c;

    state_t      state;
    logic [7:0]  sh;
    logic [2:0]  bcnt;
    logic        got;
    logic        rw;
    logic        nack;
    logic [4:0]  ptr;
    logic [1:0]  en;
    logic [7:0]  atime_q;
    logic [1:0]  again_q;
    logic        avalid;
    logic        sda_oe_q;
    logic        busy_q;
    logic        reg_wr_q;
    logic [4:0]  reg_wr_addr_q;

    logic        rd_load;
    logic [7:0]  rd_data;
    logic [15:0] src_c;
    logic [15:0] src_r;
    logic [15:0] src_g;
    logic [15:0] src_b;

    assign pad = {bus.scl_i, bus.sda_i};

    // Two-flop synchronizer followed by a consecutive-sample glitch filter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 2'b11;
            sync2  <= 2'b11;
            filt   <= 2'b11;
            filt_q <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                flt_cnt[i] <= '0;
            end
        end else begin
            sync1  <= pad;
            sync2  <= sync1;
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == CNT_MAX) begin
                    filt[i]    <= sync2[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign scl      = filt[1];
    assign sda      = filt[0];
    assign scl_rise = scl & ~filt_q[1];
    assign scl_fall = ~scl & filt_q[1];
    assign start_c  = scl & filt_q[1] & filt_q[0] & ~sda;
    assign stop_c   = scl & filt_q[1] & ~filt_q[0] & sda;

    // A read byte is fetched when leaving an ACK slot towards RD_BYTE.
    assign rd_load = scl_fall & ~start_c & ~stop_c &
                     (((state == ADDR_ACK) & rw) |
                      ((state == RD_ACK) & ~nack));

`ifdef TCS_SHADOW_LATCH_EN
    logic [15:0] sh_c;
    logic [15:0] sh_r;
    logic [15:0] sh_g;
    logic [15:0] sh_b;

    // Snapshot all channels when CDATAL is fetched for a read.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_c <= '0;
            sh_r <= '0;
            sh_g <= '0;
            sh_b <= '0;
        end else if (rd_load && ptr == 5'h14) begin
            sh_c <= clear_in;
            sh_r <= red_in;
            sh_g <= green_in;
            sh_b <= blue_in;
        end
    end

    assign src_c = sh_c;
    assign src_r = sh_r;
    assign src_g = sh_g;
    assign src_b = sh_b;
`else
    assign src_c = clear_in;
    assign src_r = red_in;
    assign src_g = green_in;
    assign src_b = blue_in;
`endif

    // Register read mux; CDATAL comes live since it is the snapshot byte.
    always_comb begin
        rd_data = 8'h00;
        case (ptr)
            5'h00:   rd_data = {6'b0, en};
            5'h01:   rd_data = atime_q;
            5'h0F:   rd_data = {6'b0, again_q};
            5'h12:   rd_data = ID_VALUE;
            5'h13:   rd_data = {7'b0, avalid};
            5'h14:   rd_data = clear_in[7:0];
            5'h15:   rd_data = src_c[15:8];
            5'h16:   rd_data = src_r[7:0];
            5'h17:   rd_data = src_r[15:8];
            5'h18:   rd_data = src_g[7:0];
            5'h19:   rd_data = src_g[15:8];
            5'h1A:   rd_data = src_b[7:0];
            5'h1B:   rd_data = src_b[15:8];
            default: rd_data = 8'h00;
        endcase
    end

    // Protocol FSM, register file and registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sh            <= '0;
            bcnt          <= '0;
            got           <= 1'b0;
            rw            <= 1'b0;
            nack          <= 1'b0;
            ptr           <= '0;
            en            <= '0;
            atime_q       <= 8'hFF;
            again_q       <= '0;
            avalid        <= 1'b0;
            sda_oe_q      <= 1'b0;
            busy_q        <= 1'b0;
            reg_wr_q      <= 1'b0;
            reg_wr_addr_q <= '0;
        end else begin
            reg_wr_q <= 1'b0;
            if (start_c) begin
                state    <= ADDR;
                bcnt     <= '0;
                got      <= 1'b0;
                sda_oe_q <= 1'b0;
            end else if (stop_c) begin
                state    <= IDLE;
                got      <= 1'b0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                unique case (state)
                    ADDR, CMD, WR_BYTE: begin
                        if (scl_rise) begin
                            sh   <= {sh[6:0], sda};
                            bcnt <= bcnt + 3'd1;
                            if (bcnt == 3'd7) got <= 1'b1;
                        end else if (scl_fall && got) begin
                            got <= 1'b0;
                            if (state == ADDR) begin
                                if (sh[7:1] == DEVICE_ADDRESS) begin
                                    state    <= ADDR_ACK;
                                    sda_oe_q <= 1'b1;
                                    rw       <= sh[0];
                                    busy_q   <= 1'b1;
                                end else begin
                                    state <= IGNORE;
                                end
                            end else if (state == CMD) begin
                                state    <= CMD_ACK;
                                sda_oe_q <= 1'b1;
                                if (sh[7]) ptr <= sh[4:0];
                            end else begin
                                state         <= WR_ACK;
                                sda_oe_q      <= 1'b1;
                                reg_wr_q      <= 1'b1;
                                reg_wr_addr_q <= ptr;
                                ptr           <= ptr + 5'd1;
                                if (ptr == 5'h00) begin
                                    en <= sh[1:0];
                                    if (!sh[1]) avalid <= 1'b0;
                                end else if (ptr == 5'h01) begin
                                    atime_q <= sh;
                                end else if (ptr == 5'h0F) begin
                                    again_q <= sh[1:0];
                                end
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bcnt <= '0;
                            got  <= 1'b0;
                            if (rd_load) begin
                                state    <= RD_BYTE;
                                sh       <= rd_data;
                                sda_oe_q <= ~rd_data[7];
                            end else begin
                                state    <= CMD;
                                sda_oe_q <= 1'b0;
                            end
                        end
                    end
                    CMD_ACK, WR_ACK: begin
                        if (scl_fall) begin
                            state    <= WR_BYTE;
                            sda_oe_q <= 1'b0;
                            bcnt     <= '0;
                            got      <= 1'b0;
                        end
                    end
                    RD_BYTE: begin
                        if (scl_rise) begin
                            bcnt <= bcnt + 3'd1;
                            if (bcnt == 3'd7) got <= 1'b1;
                        end else if (scl_fall) begin
                            if (got) begin
                                got      <= 1'b0;
                                sda_oe_q <= 1'b0;
                                ptr      <= ptr + 5'd1;
                                state    <= RD_ACK;
                            end else begin
                                sh       <= {sh[6:0], 1'b0};
                                sda_oe_q <= ~sh[6];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            nack <= sda;
                        end else if (scl_fall) begin
                            bcnt <= '0;
                            got  <= 1'b0;
                            if (rd_load) begin
                                state    <= RD_BYTE;
                                sh       <= rd_data;
                                sda_oe_q <= ~rd_data[7];
                            end else begin
                                state    <= IGNORE;
                                sda_oe_q <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            // A fresh conversion wins over a same-cycle ENABLE clear.
            if (data_valid_in) avalid <= 1'b1;
        end
    end

    assign bus.sda_oe  = sda_oe_q;
    assign busy        = busy_q;
    assign reg_wr      = reg_wr_q;
    assign reg_wr_addr = reg_wr_addr_q;
    assign pon         = en[0];
    assign aen         = en[1];
    assign atime       = atime_q;
    assign again       = again_q;

endmodule
